uart_rx: RTL and testbench

- Receive half of the RS-232 UART link.
- Samples the asynchronous serial line `rx_in` using an oversampling tick from the shared baud generator.
- Decodes frames of 1 start bit, DATA_BITS data bits (LSB first) and 1 stop bit; no parity.
- Presents each received byte with a one-cycle valid strobe and flags framing errors; idle-high line polarity matches the transmitter.

---
 rtl/uart_rx_if.sv | 45 ++++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//
// Bundles the UART receiver's tick/line inputs and its received-word outputs.
//
// Signals:
//   os_tick   - one-clk pulse at OVERSAMPLE x baud rate (from baud generator)
//   rx_in     - asynchronous serial line, idle high
//   rx_data   - last good received word
//   rx_valid  - one-clk pulse: rx_data updated
//   frame_err - one-clk pulse: stop bit sampled low
//   rx_busy   - high from start-bit detect until return to idle
//
// Modports:
//   master - the receiver itself (consumes tick/line, produces word/status)
//   slave  - the surrounding logic (drives tick/line, consumes word/status)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 os_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        input  os_tick,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output os_tick,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Receive half of the RS-232 UART link. Oversamples the asynchronous line
// with os_tick and decodes 1 start bit, DATA_BITS data bits (LSB first) and
// 1 stop bit, no parity. Each good word is presented with a one-cycle
// rx_valid strobe; a low stop bit gives a one-cycle frame_err strobe and the
// receiver then waits for the line to go idle (break handling).
//
// Parameters:
//   OVERSAMPLE - os_tick pulses per bit period; even, >= 4
//   DATA_BITS  - data bits per frame, 5..8
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - uart_rx_if.master: os_tick, rx_in in; rx_data, rx_valid,
//          frame_err, rx_busy out (all outputs registered)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Start bit is checked half a bit in; data and stop bits one full bit
    // period after that, so every sample lands near mid-bit.
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [TICK_W-1:0]    tick_inc;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 sample_data;

    assign tick_inc    = tick_cnt + TICK_W'(1);
    assign sample_data = bus.os_tick && (state == DATA) && (tick_cnt == TICK_LAST);

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Reset to the idle level so a reset never
    // looks like a start bit.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx_in;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Data shift register: right shift, new bit enters at the MSB, so the
    // first (LSB) bit of the frame ends up at bit 0.
    // ------------------------------------------------------------------
    // NOTE: pure datapath with no reset; its contents only reach rx_data
    // after a complete frame has overwritten every bit.
    always_ff @(posedge clk) begin
        if (sample_data) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM. Everything advances only on os_tick; the two strobes are
    // cleared on every clk so they last exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.rx_busy   <= 1'b0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;

            if (bus.os_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state       <= START;
                            tick_cnt    <= '0;
                            bus.rx_busy <= 1'b1;
                        end
                    end

                    START: begin
                        tick_cnt <= tick_inc;
                        if (tick_inc == TICK_HALF) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                // Line went back high before mid start bit:
                                // treat as a glitch and drop it silently.
                                state       <= IDLE;
                                bus.rx_busy <= 1'b0;
                            end
                        end
                    end

                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                // Leaving at mid stop bit leaves half a bit
                                // of margin to catch a back-to-back start.
                                bus.rx_data  <= shift_q;
                                bus.rx_valid <= 1'b1;
                                bus.rx_busy  <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                bus.frame_err <= 1'b1;
                                state         <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end

                    BREAK: begin
                        // Wait out a held-low line so a break produces a
                        // single frame_err rather than a stream of frames.
                        if (rx_s) begin
                            state       <= IDLE;
                            bus.rx_busy <= 1'b0;
                        end
                    end

                    default: begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx (OVERSAMPLE=16, DATA_BITS=8, os_tick every 4
// clk). A frame-level model predicts the outputs from tick offsets measured
// from start-bit detection; a compare process checks every cycle, and each
// scenario also checks hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int HALF    = OS / 2;
    localparam int BIT_CLK = OS * 4;

    typedef enum {M_IDLE, M_FRAME, M_BREAK} mmode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic          m1 = 1'b1;
    logic          m2 = 1'b1;
    mmode_t        mode = M_IDLE;
    int            tick_idx = 0;
    int            t0 = 0;
    logic [DB-1:0] word = '0;
    logic          exp_busy = 1'b0;
    logic          exp_valid = 1'b0;
    logic          exp_ferr = 1'b0;
    logic [DB-1:0] exp_data = '0;
    logic [DB-1:0] mq[$];

    task automatic model_step();
        logic synced;
        int   k;
        int   n;
        synced    = m2;
        m2        = m1;
        m1        = bus.rx_in;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (rst) begin
            m1       = 1'b1;
            m2       = 1'b1;
            mode     = M_IDLE;
            exp_data = '0;
            exp_busy = 1'b0;
            return;
        end
        if (bus.os_tick) begin
            tick_idx++;
            case (mode)
                M_IDLE: begin
                    if (!synced) begin
                        mode = M_FRAME;
                        t0   = tick_idx;
                    end
                end
                M_FRAME: begin
                    k = tick_idx - t0;
                    if (k == HALF - 1) begin
                        if (synced) mode = M_IDLE;
                    end else if (k > HALF - 1 && (k - (HALF - 1)) % OS == 0) begin
                        n = (k - (HALF - 1)) / OS;
                        if (n <= DB) begin
                            word[n-1] = synced;
                        end else if (synced) begin
                            exp_data  = word;
                            exp_valid = 1'b1;
                            mq.push_back(word);
                            mode = M_IDLE;
                        end else begin
                            exp_ferr = 1'b1;
                            mode     = M_BREAK;
                        end
                    end
                end
                M_BREAK: begin
                    if (synced) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
        end
        exp_busy = (mode != M_IDLE);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- compare + DUT strobe capture ----------------
    logic [DB-1:0] dq[$];
    int            ferr_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("cycle {busy,valid,ferr,data}",
                  {53'd0, bus.rx_busy, bus.rx_valid, bus.frame_err, bus.rx_data},
                  {53'd0, exp_busy, exp_valid, exp_ferr, exp_data});
            if (bus.rx_valid) dq.push_back(bus.rx_data);
            if (bus.frame_err) ferr_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.os_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.os_tick = 1'b1;
            @(negedge clk);
            bus.os_tick = 1'b0;
        end
    end

    task automatic line(input logic v, input int nclk);
        bus.rx_in = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input int bclk, input logic stop_bit);
        line(1'b0, bclk);
        for (int i = 0; i < DB; i++) line(d[i], bclk);
        line(stop_bit, bclk);
    endtask

    task automatic clear_logs();
        dq.delete();
        mq.delete();
        ferr_cnt = 0;
    endtask

    initial begin
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, bus.rx_busy}, 64'd0);
        check("reset valid", {63'd0, bus.rx_valid}, 64'd0);
        check("reset ferr", {63'd0, bus.frame_err}, 64'd0);
        check("reset data", {56'd0, bus.rx_data}, 64'd0);
        rst = 1'b0;
        line(1'b1, 2 * BIT_CLK);

        // 1: single frame 0xA5
        clear_logs();
        send_frame(8'hA5, BIT_CLK, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        check("t1 strobe count", dq.size(), 64'd1);
        if (dq.size() > 0) check("t1 data", {56'd0, dq[0]}, 64'h A5);
        check("t1 model data", (mq.size() == 1) ? {56'd0, mq[0]} : 64'hDEAD, 64'hA5);
        check("t1 ferr count", ferr_cnt, 64'd0);

        // 2: back-to-back 0x00, 0xFF, 0x3C
        clear_logs();
        send_frame(8'h00, BIT_CLK, 1'b1);
        send_frame(8'hFF, BIT_CLK, 1'b1);
        send_frame(8'h3C, BIT_CLK, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        check("t2 strobe count", dq.size(), 64'd3);
        if (dq.size() == 3) begin
            check("t2 data0", {56'd0, dq[0]}, 64'h00);
            check("t2 data1", {56'd0, dq[1]}, 64'hFF);
            check("t2 data2", {56'd0, dq[2]}, 64'h3C);
        end
        check("t2 model count", mq.size(), 64'd3);

        // 3: glitch, low for 4 ticks
        clear_logs();
        line(1'b0, 4 * 4);
        check("t3 busy during glitch", {63'd0, bus.rx_busy}, 64'd1);
        line(1'b1, 2 * BIT_CLK);
        check("t3 busy after glitch", {63'd0, bus.rx_busy}, 64'd0);
        check("t3 strobe count", dq.size(), 64'd0);
        check("t3 ferr count", ferr_cnt, 64'd0);

        // 4: framing error + break, then 0x3C
        clear_logs();
        send_frame(8'h55, BIT_CLK, 1'b0);
        line(1'b0, 3 * BIT_CLK);
        check("t4 busy in break", {63'd0, bus.rx_busy}, 64'd1);
        check("t4 ferr count", ferr_cnt, 64'd1);
        check("t4 data held", {56'd0, bus.rx_data}, 64'h3C);
        line(1'b1, 2 * BIT_CLK);
        check("t4 busy after break", {63'd0, bus.rx_busy}, 64'd0);
        check("t4 no strobe", dq.size(), 64'd0);
        send_frame(8'h3C, BIT_CLK, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        check("t4 strobe count", dq.size(), 64'd1);
        if (dq.size() > 0) check("t4 data", {56'd0, dq[0]}, 64'h3C);
        check("t4 ferr total", ferr_cnt, 64'd1);

        // 5: reset during data bit 4 of 0xC3, then 0x81
        clear_logs();
        line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) line(1'(8'hC3 >> i), BIT_CLK);
        line(1'b0, BIT_CLK / 2);
        check("t5 busy before rst", {63'd0, bus.rx_busy}, 64'd1);
        rst       = 1'b1;
        bus.rx_in = 1'b1;
        @(negedge clk);
        check("t5 rst busy", {63'd0, bus.rx_busy}, 64'd0);
        check("t5 rst valid", {63'd0, bus.rx_valid}, 64'd0);
        check("t5 rst ferr", {63'd0, bus.frame_err}, 64'd0);
        check("t5 rst data", {56'd0, bus.rx_data}, 64'd0);
        rst = 1'b0;
        line(1'b1, 2 * BIT_CLK);
        check("t5 no strobe for aborted frame", dq.size(), 64'd0);
        send_frame(8'h81, BIT_CLK, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        check("t5 strobe count", dq.size(), 64'd1);
        if (dq.size() > 0) check("t5 data", {56'd0, dq[0]}, 64'h81);
        check("t5 ferr count", ferr_cnt, 64'd0);

        // 6: baud tolerance, fast then slow transmitter
        clear_logs();
        send_frame(8'h96, BIT_CLK - 2, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        send_frame(8'h96, BIT_CLK + 2, 1'b1);
        line(1'b1, 2 * BIT_CLK);
        check("t6 strobe count", dq.size(), 64'd2);
        if (dq.size() == 2) begin
            check("t6 fast data", {56'd0, dq[0]}, 64'h96);
            check("t6 slow data", {56'd0, dq[1]}, 64'h96);
        end
        check("t6 ferr count", ferr_cnt, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
